// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode enum and the status-flag bundle.
package alu_pkg;

  // Codes 000-011 match the older 4-bit ALU's s1,s0 encoding.
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_XOR  = 3'b001,
    OP_OR   = 3'b010,
    OP_NOT  = 3'b011,
    OP_SUB  = 3'b100,
    OP_AND  = 3'b101,
    OP_ADC  = 3'b110,
    OP_LOAD = 3'b111
  } op_e;

  typedef struct packed {
    logic cout;
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: one operation on (a, b, carry_in) producing result and flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] result,
  output flags_t           flags
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             cy;
  logic             arith;

  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no latch can be inferred.
    b_eff  = b;
    cy     = carry_in;
    arith  = 1'b0;
    result = '0;
    flags  = '0;

    // SUB reuses the adder as a + ~b + 1.
    case (op)
      OP_ADD, OP_ADC: arith = 1'b1;
      OP_SUB: begin
        arith = 1'b1;
        b_eff = ~b;
        cy    = 1'b1;
      end
      default: ;
    endcase

    sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cy};

    case (op)
      OP_XOR:  result = a ^ b;
      OP_OR:   result = a | b;
      OP_NOT:  result = ~a;
      OP_AND:  result = a & b;
      OP_LOAD: result = b;
      default: result = sum[WIDTH-1:0];
    endcase

    flags.cout = arith & sum[WIDTH];
    flags.zero = (result == '0);
    flags.neg  = result[MSB];
    flags.ovf  = arith && (a[MSB] == b_eff[MSB]) && (result[MSB] != a[MSB]);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU with an accumulator that is written when a result is consumed.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  logic             s1_valid_q, s1_valid_d;
  op_e              s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_cin_q, s1_cin_d;
  logic             s1_use_acc_q, s1_use_acc_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;

  logic             s1_adv, s2_adv, out_fire;
  logic [WIDTH-1:0] acc_eff, core_a, core_result;
  logic             carry_eff, core_cin;
  flags_t           core_flags;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign out_fire = s2_valid_q && out_ready;

  // A result consumed this cycle is the accumulator value the next S2 entry must see.
  assign acc_eff   = out_fire ? result_q     : acc_q;
  assign carry_eff = out_fire ? flags_q.cout : carry_q;

  assign core_a   = s1_use_acc_q ? acc_eff : s1_a_q;
  assign core_cin = (s1_op_q == OP_ADC) ? carry_eff : s1_cin_q;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op       (s1_op_q),
    .a        (core_a),
    .b        (s1_b_q),
    .carry_in (core_cin),
    .result   (core_result),
    .flags    (core_flags)
  );

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_op_d      = s1_op_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_cin_d     = s1_cin_q;
    s1_use_acc_d = s1_use_acc_q;
    s2_valid_d   = s2_valid_q;
    result_d     = result_q;
    flags_d      = flags_q;
    acc_d        = acc_q;
    carry_d      = carry_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d      = op_e'(op);
        s1_a_d       = a;
        s1_b_d       = b;
        s1_cin_d     = cin;
        s1_use_acc_d = use_acc;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = core_result;
        flags_d  = core_flags;
      end
    end

    if (out_fire) begin
      acc_d   = result_q;
      carry_d = flags_q.cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= OP_ADD;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_cin_q     <= 1'b0;
      s1_use_acc_q <= 1'b0;
      s2_valid_q   <= 1'b0;
      result_q     <= '0;
      flags_q      <= '0;
      acc_q        <= '0;
      carry_q      <= 1'b0;
    end else begin
      // NOTE: state updates are non-blocking so every flop samples pre-edge values.
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_cin_q     <= s1_cin_d;
      s1_use_acc_q <= s1_use_acc_d;
      s2_valid_q   <= s2_valid_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      acc_q        <= acc_d;
      carry_q      <= carry_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign cout      = flags_q.cout;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign ovf       = flags_q.ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed scenarios plus random traffic against an in-order model.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         cin, use_acc;
  logic         out_valid, out_ready;
  logic [W-1:0] result;
  logic         cout, zero, neg, ovf;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .use_acc   (use_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  typedef struct {
    logic [11:0] model;
    bit          has_lit;
    logic [11:0] lit;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          m_acc = 0;
  int          m_carry = 0;
  int          cyc = 0;
  bit          accepted;
  bit          has_lit_next = 0;
  logic [11:0] lit_next = '0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [11:0] pack(logic [7:0] r, logic c, logic z, logic n, logic v);
    return {r, c, z, n, v};
  endfunction

  function automatic logic [31:0] obs();
    return {20'd0, result, cout, zero, neg, ovf};
  endfunction

  // Reference: integer arithmetic, with overflow judged by the signed range of the true result.
  function automatic logic [11:0] ref_op(int o, int av, int bv, int ci, int cf);
    int  r, s, sa, sb;
    bit  c, v;
    sa = (av >= 128) ? av - 256 : av;
    sb = (bv >= 128) ? bv - 256 : bv;
    c = 0;
    v = 0;
    case (o)
      0: begin r = av + bv + ci; c = (r > 255); s = sa + sb + ci; v = (s > 127) || (s < -128); end
      1: r = av ^ bv;
      2: r = av | bv;
      3: r = ~av;
      4: begin r = av - bv; c = (av >= bv); s = sa - sb; v = (s > 127) || (s < -128); end
      5: r = av & bv;
      6: begin r = av + bv + cf; c = (r > 255); s = sa + sb + cf; v = (s > 127) || (s < -128); end
      default: r = bv;
    endcase
    r = r & 255;
    return pack(r[7:0], c, r == 0, r >= 128, v);
  endfunction

  // One clock: account for handshakes seen before the edge, then advance to the next falling edge.
  task automatic tick();
    bit   in_f, out_f;
    exp_t e;
    int   a_eff;
    #1;
    in_f  = in_valid && in_ready;
    out_f = out_valid && out_ready;
    if (out_f) begin
      if (q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("result_flags", obs(), {20'd0, e.model});
        if (e.has_lit) check("directed_value", obs(), {20'd0, e.lit});
      end
    end
    if (in_f) begin
      a_eff     = use_acc ? m_acc : int'(a);
      e.model   = ref_op(int'(op), a_eff, int'(b), int'(cin), m_carry);
      e.has_lit = has_lit_next;
      e.lit     = lit_next;
      m_acc     = int'(e.model[11:4]);
      m_carry   = int'(e.model[3]);
      has_lit_next = 0;
      q.push_back(e);
    end
    accepted = in_f;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input op_e o, input logic [7:0] av, input logic [7:0] bv, input logic ci,
                      input logic ua, input bit hl, input logic [11:0] lv);
    in_valid = 1'b1;
    op       = o;
    a        = av;
    b        = bv;
    cin      = ci;
    use_acc  = ua;
    has_lit_next = hl;
    lit_next     = lv;
    accepted = 0;
    for (int i = 0; i < 50 && !accepted; i++) tick();
    check("accept_in_time", {31'd0, accepted}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() > 0; i++) tick();
    check("drained", q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, k;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0; cin = 1'b0; use_acc = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_reset_outputs", obs(), 32'd0);
    @(negedge clk);

    // ADD with overflow and latency
    send(OP_ADD, 8'h80, 8'h80, 1'b0, 1'b0, 1, pack(8'h00, 1, 1, 0, 1));
    check("latency_edge1", {31'd0, out_valid}, 32'd0);
    tick();
    check("latency_edge2", {31'd0, out_valid}, 32'd1);
    drain();

    // SUB with borrow
    send(OP_SUB, 8'h05, 8'h07, 1'b0, 1'b0, 1, pack(8'hFE, 0, 0, 1, 0));
    drain();

    // Accumulator chain at full rate
    c0 = cyc;
    send(OP_LOAD, 8'h00, 8'h10, 1'b0, 1'b0, 1, pack(8'h10, 0, 0, 0, 0));
    send(OP_ADD,  8'h00, 8'h01, 1'b0, 1'b1, 1, pack(8'h11, 0, 0, 0, 0));
    send(OP_ADD,  8'h00, 8'h01, 1'b0, 1'b1, 1, pack(8'h12, 0, 0, 0, 0));
    check("full_rate_cycles", cyc - c0, 32'd3);
    drain();

    // ADC consumes the carry of the preceding ADD
    send(OP_ADD, 8'hFF, 8'h01, 1'b0, 1'b0, 1, pack(8'h00, 1, 1, 0, 0));
    send(OP_ADC, 8'h00, 8'h00, 1'b0, 1'b0, 1, pack(8'h01, 0, 0, 0, 0));
    drain();

    // Back-pressure: three requests offered while the consumer stalls
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; cin = 1'b0; use_acc = 1'b0; has_lit_next = 1;
      case (k)
        0: begin op = OP_ADD; a = 8'h01; b = 8'h02; lit_next = pack(8'h03, 0, 0, 0, 0); end
        1: begin op = OP_SUB; a = 8'h10; b = 8'h03; lit_next = pack(8'h0D, 1, 0, 0, 0); end
        default: begin op = OP_XOR; a = 8'hF0; b = 8'h0F; lit_next = pack(8'hFF, 0, 0, 1, 0); end
      endcase
      tick();
      if (accepted) k++;
      if (c >= 2) begin
        check("stall_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("stall_result_held", {24'd0, result}, 32'h03);
      end
    end
    check("stall_acceptances", k, 32'd2);
    out_ready = 1'b1;
    send(OP_XOR, 8'hF0, 8'h0F, 1'b0, 1'b0, 1, pack(8'hFF, 0, 0, 1, 0));
    drain();

    // Reset with both stages occupied
    out_ready = 1'b0;
    send(OP_ADD, 8'h01, 8'h01, 1'b0, 1'b0, 0, '0);
    send(OP_ADD, 8'h02, 8'h02, 1'b0, 1'b0, 0, '0);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    q.delete();
    m_acc = 0;
    m_carry = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(OP_ADD, 8'h00, 8'h03, 1'b0, 1'b1, 1, pack(8'h03, 0, 0, 0, 0));
    drain();

    // Random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op        = 3'($urandom_range(0, 7));
      a         = 8'($urandom);
      b         = 8'($urandom);
      cin       = 1'($urandom);
      use_acc   = 1'($urandom);
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
